// File: rtl/reg_file_onehot.sv
// 16-entry register file addressed by one-hot selects (bit 15 = R0, bit 0 = R15).
// Optional same-cycle write-through forwarding is enabled by defining REGFILE_WR_BYPASS_EN.
module reg_file_onehot #(
  parameter int DATA_WIDTH = 32,
  parameter bit R0_BA_ZERO = 1'b1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  Rin,
  input  logic [15:0]           WriteSel,
  input  logic [DATA_WIDTH-1:0] BusMuxIn,
  input  logic                  Rout,
  input  logic                  BAout,
  input  logic [15:0]           ReadSel,
  output logic [DATA_WIDTH-1:0] BusMuxOut,
  output logic                  sel_err,
  output logic [15:0]           written
);

  logic [DATA_WIDTH-1:0] regs [16];
  logic                  wr_en;
  logic                  wr_bad;
  logic                  rd_ok;
  logic                  rd_bad;
  logic [DATA_WIDTH-1:0] rd_data;

  function automatic logic multi_hot(input logic [15:0] v);
    return (v & (v - 16'd1)) != 16'd0;
  endfunction

  function automatic logic one_hot(input logic [15:0] v);
    return (v != 16'd0) && !multi_hot(v);
  endfunction

  assign wr_en  = Rin && one_hot(WriteSel);
  assign wr_bad = Rin && multi_hot(WriteSel);
  assign rd_ok  = Rout && one_hot(ReadSel);
  assign rd_bad = Rout && multi_hot(ReadSel);

  // Storage, debug bitmap and sticky error; clear wins over any write
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= '0;
      end
      written <= 16'd0;
      sel_err <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (wr_en && WriteSel[i]) begin
          regs[i]    <= BusMuxIn;
          written[i] <= 1'b1;
        end
      end
      if (wr_bad || rd_bad) begin
        sel_err <= 1'b1;
      end
    end
  end

  // Read mux; illegal or absent selects read as zero
  always_comb begin
    rd_data = '0;
    if (rd_ok) begin
      for (int i = 0; i < 16; i++) begin
        if (ReadSel[i]) begin
          rd_data = regs[i];
        end
      end
`ifdef REGFILE_WR_BYPASS_EN
      if (Rin && (WriteSel == ReadSel)) begin
        rd_data = BusMuxIn;
      end
`endif
      if (R0_BA_ZERO && BAout && ReadSel[15]) begin
        rd_data = '0;
      end
    end
  end

  assign BusMuxOut = rd_data;

endmodule

// File: tb/tb_reg_file_onehot.sv
// Bench for reg_file_onehot: vector table for reset/write/read sweeps plus hand sequences,
// expected values queued on drive and popped at the sample point.
module tb_reg_file_onehot;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        Rin = 1'b0;
  logic [15:0] WriteSel = 16'd0;
  logic [31:0] BusMuxIn = 32'd0;
  logic        Rout = 1'b0;
  logic        BAout = 1'b0;
  logic [15:0] ReadSel = 16'd0;
  logic [31:0] BusMuxOut;
  logic        sel_err;
  logic [15:0] written;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic        clr;
    logic        rin;
    logic [15:0] wsel;
    logic [31:0] din;
    logic        rout;
    logic        ba;
    logic [15:0] rsel;
    logic [31:0] exp_out;
    logic        exp_err;
    logic [15:0] exp_wr;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] out;
    logic        err;
    logic [15:0] wr;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  reg_file_onehot #(.DATA_WIDTH(32), .R0_BA_ZERO(1'b1)) dut (
    .clock(clock), .clear(clear), .Rin(Rin), .WriteSel(WriteSel),
    .BusMuxIn(BusMuxIn), .Rout(Rout), .BAout(BAout), .ReadSel(ReadSel),
    .BusMuxOut(BusMuxOut), .sel_err(sel_err), .written(written)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic clr, input logic rin, input logic [15:0] wsel,
                              input logic [31:0] din, input logic rout, input logic ba,
                              input logic [15:0] rsel, input logic [31:0] eo,
                              input logic ee, input logic [15:0] ew, input string nm);
    vec_t v;
    v.clr = clr; v.rin = rin; v.wsel = wsel; v.din = din; v.rout = rout; v.ba = ba;
    v.rsel = rsel; v.exp_out = eo; v.exp_err = ee; v.exp_wr = ew; v.name = nm;
    return v;
  endfunction

  // Drive one cycle's inputs after the falling edge, sample just before the rising edge.
  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clock);
    clear = v.clr; Rin = v.rin; WriteSel = v.wsel; BusMuxIn = v.din;
    Rout = v.rout; BAout = v.ba; ReadSel = v.rsel;
    sb.push_back('{v.exp_out, v.exp_err, v.exp_wr, v.name});
    #2;
    e = sb.pop_front();
    checks++;
    if (BusMuxOut !== e.out) begin
      fails++;
      $display("FAIL %s BusMuxOut got %h want %h", e.name, BusMuxOut, e.out);
    end
    checks++;
    if (sel_err !== e.err) begin
      fails++;
      $display("FAIL %s sel_err got %b want %b", e.name, sel_err, e.err);
    end
    checks++;
    if (written !== e.wr) begin
      fails++;
      $display("FAIL %s written got %h want %h", e.name, written, e.wr);
    end
  endtask

  initial begin
    logic [15:0] sel;
    logic [15:0] ones;
    logic [31:0] same_exp;

    ones = 16'hFFFF;
    // Reset sweep: every register reads zero after clear
    for (int k = 0; k < 16; k++) begin
      sel = 16'h8000 >> k;
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, sel, 32'd0, 0, 16'd0, "reset_read"));
    end
    // Write then read back each register
    for (int k = 0; k < 16; k++) begin
      sel = 16'h8000 >> k;
      vecs.push_back(mk(0, 1, sel, 32'hA5A50000 + k, 0, 0, 16'd0, 32'd0, 0,
                        ~(ones >> k), "write_each"));
      vecs.push_back(mk(0, 0, 16'd0, 32'd0, 1, 0, sel, 32'hA5A50000 + k, 0,
                        ~(ones >> (k + 1)), "read_each"));
    end

    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    foreach (vecs[i]) step(vecs[i]);

    // R0 base-address masking
    step(mk(0, 1, 16'h8000, 32'h1234, 0, 0, 0, 32'd0, 0, 16'hFFFF, "r0_write"));
    step(mk(0, 0, 0, 0, 1, 0, 16'h8000, 32'h1234, 0, 16'hFFFF, "r0_ba0"));
    step(mk(0, 0, 0, 0, 1, 1, 16'h8000, 32'h0, 0, 16'hFFFF, "r0_ba1"));
    step(mk(0, 0, 0, 0, 1, 1, 16'h4000, 32'hA5A50001, 0, 16'hFFFF, "r1_ba1"));

    // Illegal write select leaves R3/R4 alone and sets sticky error
    step(mk(0, 1, 16'h1000, 32'h11, 0, 0, 0, 32'd0, 0, 16'hFFFF, "r3_write"));
    step(mk(0, 1, 16'h1800, 32'hFF, 0, 0, 0, 32'd0, 0, 16'hFFFF, "illegal_wr"));
    step(mk(0, 0, 0, 0, 1, 0, 16'h1000, 32'h11, 1, 16'hFFFF, "r3_kept"));
    step(mk(0, 0, 0, 0, 1, 0, 16'h0800, 32'hA5A50004, 1, 16'hFFFF, "r4_kept"));
    for (int i = 0; i < 10; i++)
      step(mk(0, 0, 0, 0, 1, 0, 16'h4000, 32'hA5A50001, 1, 16'hFFFF, "err_sticky"));
    step(mk(1, 0, 0, 0, 0, 0, 0, 32'd0, 1, 16'hFFFF, "clear_err"));
    step(mk(0, 1, 16'h0000, 32'h77, 0, 0, 0, 32'd0, 0, 16'h0000, "err_cleared"));
    step(mk(0, 0, 16'hE000, 32'h0, 0, 0, 0, 32'd0, 0, 16'h0000, "zero_wsel_ok"));
    step(mk(0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 16'h0000, "rin0_ignored"));

    // Multi-hot read select
    step(mk(0, 0, 0, 0, 1, 0, 16'hC000, 32'd0, 0, 16'h0000, "rd_multi"));
    step(mk(0, 0, 0, 0, 1, 0, 16'h8000, 32'd0, 1, 16'h0000, "rd_err_set"));
    step(mk(1, 0, 0, 0, 0, 0, 0, 32'd0, 1, 16'h0000, "clear2"));

    // Same-cycle write/read of R5
`ifdef REGFILE_WR_BYPASS_EN
    same_exp = 32'h55;
`else
    same_exp = 32'h5;
`endif
    step(mk(0, 1, 16'h0400, 32'h5, 0, 0, 0, 32'd0, 0, 16'h0000, "r5_write5"));
    step(mk(0, 1, 16'h0400, 32'h55, 1, 0, 16'h0400, same_exp, 0, 16'h0400, "r5_same"));
    step(mk(0, 0, 0, 0, 1, 0, 16'h0400, 32'h55, 0, 16'h0400, "r5_next"));
    step(mk(0, 0, 0, 0, 0, 0, 16'h0400, 32'd0, 0, 16'h0400, "rout0"));
    step(mk(0, 1, 16'h8000, 32'hAB, 1, 1, 16'h8000, 32'd0, 0, 16'h0400, "r0_fwd_mask"));
    step(mk(0, 0, 0, 0, 1, 0, 16'h8000, 32'hAB, 0, 16'h8400, "r0_stored"));

    // Clear beats a simultaneous write; reads in that cycle see old contents
    step(mk(1, 1, 16'h0400, 32'hDEAD, 1, 0, 16'h0400, 32'h55, 0, 16'h8400, "clear_rd_old"));
    step(mk(0, 0, 0, 0, 1, 0, 16'h0400, 32'd0, 0, 16'h0000, "clear_drop"));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_onehot.md
Name: reg_file_onehot

Overview:
- 16-entry general-purpose register file, R0..R15; sits directly downstream of the 4-to-16 register-select decoder.
- Consumes the decoder's one-hot select vectors for write and read, using the MSB-first mapping: bit 15 = R0, bit 0 = R15.
- Writes are captured from the datapath bus on the clock edge. The selected register drives the read port combinationally.
- Keeps a sticky select-error flag and a per-register written bitmap for debug and verification.

Parameters:
- DATA_WIDTH, 32, width of each register and of the bus ports.
- R0_BA_ZERO, 1, when 1, R0 reads as zero while BAout is high (base-address addressing).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  reset; synchronous, active-high.
- Rin  in  1  write strobe.
- WriteSel  in  16  one-hot write select from decoder; bit 15 = R0.
- BusMuxIn  in  DATA_WIDTH  write data.
- Rout  in  1  read enable.
- BAout  in  1  base-address read qualifier for R0.
- ReadSel  in  16  one-hot read select from decoder; bit 15 = R0.
- BusMuxOut  out  DATA_WIDTH  read data, combinational.
- sel_err  out  1  sticky flag; set on an illegal (multi-hot) select.
- written  out  16  bit i set once register mapped to bit i has been written; same mapping as the select vectors.

Behaviour:
- Reset (clear=1 at rising edge):
  - all 16 registers <= 0, sel_err <= 0, written <= 0.
  - clear has priority over any simultaneous write.
- Write (rising edge, clear=0, Rin=1):
  - WriteSel exactly one-hot at bit k: register for bit k <= BusMuxIn; written[k] <= 1. Write visible on BusMuxOut from the next cycle (latency 1).
  - WriteSel == 0: no write, no error.
  - WriteSel with two or more bits set: no register changes, written unchanged, sel_err <= 1.
- Rin=0: WriteSel ignored entirely; no error check on it.
- Read (combinational):
  - Rout=1 and ReadSel one-hot at bit k: BusMuxOut = register k.
  - Exception: if k = 15 (R0), R0_BA_ZERO=1 and BAout=1, BusMuxOut = 0.
  - Rout=0, or ReadSel == 0: BusMuxOut = 0.
  - ReadSel multi-hot with Rout=1: BusMuxOut = 0, and sel_err <= 1 at the next rising edge (if clear=0).
- sel_err:
  - once set, stays set until clear.
  - write and read errors in the same cycle set it once; no other effect.
- Simultaneous read and write of the same register: BusMuxOut shows the old value in that cycle (see Optional Feature).
- R0 itself is a normal writable register. BAout only masks its read value, never its stored contents.
- Reset mid-sequence: a write pending in the clear cycle is dropped; reads during clear still return current (pre-reset) contents combinationally.
- No X propagation: all outputs are defined for any input pattern, including X-free illegal selects.

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN.
- Defined:
  - if Rin=1, Rout=1, and WriteSel == ReadSel with both the same legal one-hot value, BusMuxOut = BusMuxIn in the same cycle (write-through forward).
  - R0/BAout masking still applies after the forward.
  - The integrator must not close a combinational loop through the bus mux when enabled.
- Undefined: no forwarding; the same-cycle read returns the pre-write value.

Test Plan:
- Reset then read all: clear=1 for one cycle, then Rout=1 with ReadSel stepping 16'h8000..16'h0001 -> BusMuxOut=0 for every register; sel_err=0; written=16'h0000.
- Write/read each: for k=0..15, Rin=1, WriteSel=16'h8000>>k, BusMuxIn=32'hA5A50000+k; then read the same select -> BusMuxOut=32'hA5A50000+k; written=16'hFFFF at the end.
- R0 base-address: R0=32'h0000_1234, Rout=1, ReadSel=16'h8000 -> BusMuxOut=32'h1234 with BAout=0; BusMuxOut=0 with BAout=1. R1 (ReadSel=16'h4000) is unaffected by BAout.
- Illegal write select: R3=32'h11, then Rin=1, WriteSel=16'h1800, BusMuxIn=32'hFF -> R3 still 32'h11, R4 unchanged, sel_err=1 next cycle. sel_err stays 1 through 10 legal cycles and clears only after clear=1.
- Same-cycle write/read of R5 (old 32'h5, new 32'h55):
  - with REGFILE_WR_BYPASS_EN: BusMuxOut=32'h55 in that cycle.
  - without it: BusMuxOut=32'h5 in that cycle.
  - in both builds: BusMuxOut=32'h55 the next cycle.
- Clear vs write: clear=1 and Rin=1, WriteSel=16'h0400, BusMuxIn=32'hDEAD in the same cycle -> R5=0 and written[10]=0 afterwards.
